ext_uart_tx: RTL and testbench
==============================

# ext_uart_tx

Memory-mapped UART transmitter that sits on the SoC external bus (16-bit address, strobe/ack, 4-bit byte write enables, 32-bit data) as a slave, directly downstream of the `soc` external-bus master. Software pushes bytes into a TX FIFO. A serializer drains them as 8N1 frames on `o_tx`. Status and interrupt-enable registers let firmware poll or take an interrupt when transmission completes.

## Interface
- `CLK_DIV`, 868 — clock cycles per bit; must be ≥ 2.
- `FIFO_DEPTH`, 16 — TX FIFO entries; power of two, ≥ 2.
- `i_clk` in 1 — sole clock; all logic on its rising edge.
- `i_rst_n` in 1 — asynchronous, active-low reset.
- `i_ext_addr` in 16 — byte address; only bits [3:2] are decoded.
- `i_ext_stb` in 1 — bus request; held by the master until `o_ext_ack`.
- `i_ext_we` in 4 — byte write enables; nonzero means write, zero means read.
- `o_ext_ack` out 1 — single-cycle transfer-complete pulse.
- `i_ext_dat_w` in 32 — write data.
- `o_ext_dat_r` out 32 — read data; valid only while `o_ext_ack` is high, otherwise 0.
- `o_tx` out 1 — serial output; idles high.
- `o_irq` out 1 — level interrupt; equals `CTRL.irq_en & FIFO empty & serializer idle`.

## Operation
- Register map, by `i_ext_addr[3:2]`:
  - 0 DATA:
    - Write with `i_ext_we[0]` set pushes `i_ext_dat_w[7:0]`.
    - Write with `i_ext_we[0]` clear is acked with no push.
    - Read returns 0.
  - 1 STATUS (read-only):
    - bit0 full, bit1 empty, bit2 busy.
    - bits[15:8] FIFO level, zero-extended.
    - Writes are ignored.
  - 2 CTRL:
    - bit0 `irq_en`; written when `i_ext_we[0]` is set.
    - Reads return `{31'b0, irq_en}`.
  - 3: reads 0, writes ignored, always acked.
- Bus handshake:
  - `i_ext_stb` high with `o_ext_ack` low in cycle N → `o_ext_ack` high in cycle N+1, for one cycle.
  - `i_ext_stb` is ignored during the ack cycle, so a held strobe is never accepted twice.
- Full-FIFO write to DATA: the ack is withheld while full. The transfer is accepted, pushed and acked on the first edge where level < `FIFO_DEPTH`. There is no overflow and no dropped bytes.
- FIFO:
  - Circular buffer with `$clog2(FIFO_DEPTH)`-bit read/write pointers wrapping at `FIFO_DEPTH`.
  - Level counter is `$clog2(FIFO_DEPTH)+1` bits.
  - Push and pop on the same edge leave the level unchanged.
  - A pop is never issued when empty.
- Serializer FSM (IDLE, START, DATA, STOP):
  - IDLE → START when the FIFO is non-empty. Pop into the shift register; `o_tx` = 0.
  - START → DATA after `CLK_DIV` cycles.
  - DATA shifts LSB-first. It holds each bit `CLK_DIV` cycles; a 3-bit counter sets the bit index. After bit 7 → STOP, `o_tx` = 1.
  - STOP after `CLK_DIV` cycles:
    - FIFO non-empty → START directly (pop, no idle gap).
    - FIFO empty → IDLE.
- busy = (state ≠ IDLE).
- A baud counter counts 0..`CLK_DIV`-1 and reloads at each bit boundary.

## Timing
- Reset values:
  - `o_tx` = 1, `o_ext_ack` = 0, `o_ext_dat_r` = 0, `o_irq` = 0.
  - FIFO empty, pointers 0, `irq_en` = 0, state IDLE.
- Reset is asynchronous and can occur mid-frame or mid-transfer. `o_tx` returns high immediately and a pending ack is dropped. FIFO contents are discarded.
- Ack latency: one cycle unless stalled by a full FIFO.
- Push latency: the byte is written on the same edge that raises `o_ext_ack`.
- Start-bit latency into an idle serializer: `o_tx` falls on the edge following the push edge.
- Frame length is exactly 10×`CLK_DIV` cycles; back-to-back frames are contiguous.
- STATUS and `o_irq` reflect registered state and lag a push/pop by one edge at most.

## Structure
- Shared package `ext_bus_pkg`:
  - Register offset constants (`REG_DATA`, `REG_STATUS`, `REG_CTRL`) and STATUS bit positions.
  - Serializer state enum `uart_tx_state_t`.
- One natural sub-module: `sync_fifo` (parameters `WIDTH`, `DEPTH`; push/pop/full/empty/level).
- Bus decode and the serializer stay in `ext_uart_tx`.

## Test plan
Run with `CLK_DIV` = 4, `FIFO_DEPTH` = 4.

- Reset, idle: after release, `o_tx` = 1, `o_irq` = 0. A STATUS read is acked one cycle after strobe with `o_ext_dat_r` = 0x0000_0002.
- Single byte: write DATA = 0x55.
  - `o_tx` sequence 0,1,0,1,0,1,0,1,0,1, each level 4 cycles, 40 cycles total.
  - Then busy = 0.
- Back-to-back and backpressure: write 0xA0–0xA5 without polling.
  - The first writes ack in 1 cycle; the write that meets a full FIFO is held until a pop.
  - All six frames go out contiguous, in order, with no missing byte.
- Interrupt: write CTRL = 1, then DATA = 0x0F.
  - `o_irq` = 0 during the frame.
  - `o_irq` = 1 after the stop bit ends.
  - Writing CTRL = 0 clears it.
- Held strobe / edge cases:
  - Strobe held through the ack produces exactly one push.
  - DATA write with `i_ext_we` = 4'b0010 → acked, level unchanged.
  - Offset 0xC read → 0.
- Mid-frame reset: assert `i_rst_n` low during bit 3 of a frame.
  - `o_tx` = 1 asynchronously and the FIFO is emptied.
  - No frame resumes after release.

Source files
------------

// File: rtl/ext_bus_pkg.sv
// Shared definitions for the external-bus UART transmitter: register offsets,
// STATUS bit positions and the serializer state encoding.
package ext_bus_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_LEVEL_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_tx_state_t;

endpackage

// File: rtl/ext_uart_tx_if.sv
// SoC external-bus slave port: 16-bit byte address, strobe/ack handshake,
// 4-bit byte write enables, 32-bit data in each direction.
interface ext_uart_tx_if;
  logic [15:0] i_ext_addr;
  logic        i_ext_stb;
  logic [3:0]  i_ext_we;
  logic [31:0] i_ext_dat_w;
  logic        o_ext_ack;
  logic [31:0] o_ext_dat_r;

  modport master (
    output i_ext_addr, i_ext_stb, i_ext_we, i_ext_dat_w,
    input  o_ext_ack, o_ext_dat_r
  );

  modport slave (
    input  i_ext_addr, i_ext_stb, i_ext_we, i_ext_dat_w,
    output o_ext_ack, o_ext_dat_r
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with an explicit occupancy counter.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // NOTE: the storage array has no reset; pointers and level alone define which
  // entries are valid, and an unreset array can map onto RAM.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

// File: rtl/ext_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus register decode, TX FIFO and a
// serializer that drains the FIFO back-to-back onto o_tx.
module ext_uart_tx
  import ext_bus_pkg::*;
#(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  ext_uart_tx_if.slave  ext_bus,
  output logic          o_tx,
  output logic          o_irq
);
  localparam int BW = $clog2(CLK_DIV);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

  logic           r_ack;
  logic [31:0]    r_dat_r;
  logic           r_irq_en;
  uart_tx_state_t r_state;
  logic           r_tx;
  logic [BW-1:0]  r_baud;
  logic [2:0]     r_bit_idx;
  logic [7:0]     r_shift;

  logic [1:0]     w_reg;
  logic           w_is_write;
  logic           w_push_req;
  logic           w_accept;
  logic           w_push;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  logic [LW-1:0]  w_level;
  logic [7:0]     w_fifo_data;
  logic [31:0]    w_rdata;
  logic           w_baud_done;
  logic           w_unused_bits;

  assign w_reg      = ext_bus.i_ext_addr[3:2];
  assign w_is_write = |ext_bus.i_ext_we;
  assign w_push_req = w_is_write && (w_reg == REG_DATA) && ext_bus.i_ext_we[0];
  // A DATA push into a full FIFO is held off; the master keeps strobing.
  assign w_accept   = ext_bus.i_ext_stb && !r_ack && !(w_push_req && w_full);
  assign w_push     = w_accept && w_push_req;
  assign w_baud_done = (r_baud == BAUD_LAST);
  assign w_pop      = !w_empty &&
                      ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_baud_done));

  assign w_unused_bits = ^{ext_bus.i_ext_addr[15:4], ext_bus.i_ext_addr[1:0],
                           ext_bus.i_ext_dat_w[31:8]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_data  (ext_bus.i_ext_dat_w[7:0]),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_rdata = '0;
    if (!w_is_write) begin
      case (w_reg)
        REG_STATUS: begin
          w_rdata[STAT_FULL]               = w_full;
          w_rdata[STAT_EMPTY]              = w_empty;
          w_rdata[STAT_BUSY]               = (r_state != ST_IDLE);
          w_rdata[STAT_LEVEL_LSB +: 8]     = 8'(w_level);
        end
        REG_CTRL: w_rdata[0] = r_irq_en;
        default:  w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ack    <= 1'b0;
      r_dat_r  <= '0;
      r_irq_en <= 1'b0;
    end else begin
      r_ack   <= w_accept;
      r_dat_r <= w_accept ? w_rdata : '0;
      if (w_accept && w_is_write && (w_reg == REG_CTRL) && ext_bus.i_ext_we[0])
        r_irq_en <= ext_bus.i_ext_dat_w[0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_tx      <= 1'b1;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_baud <= ((r_state == ST_IDLE) || w_baud_done) ? '0 : r_baud + 1'b1;
      case (r_state)
        ST_IDLE: if (!w_empty) begin
          r_state <= ST_START;
          r_shift <= w_fifo_data;
          r_tx    <= 1'b0;
        end
        ST_START: if (w_baud_done) begin
          r_state   <= ST_DATA;
          r_tx      <= r_shift[0];
          r_shift   <= {1'b0, r_shift[7:1]};
          r_bit_idx <= '0;
        end
        ST_DATA: if (w_baud_done) begin
          if (r_bit_idx == 3'd7) begin
            r_state <= ST_STOP;
            r_tx    <= 1'b1;
          end else begin
            r_bit_idx <= r_bit_idx + 1'b1;
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
          end
        end
        ST_STOP: if (w_baud_done) begin
          // Chain straight into the next start bit when more data is queued.
          if (!w_empty) begin
            r_state <= ST_START;
            r_shift <= w_fifo_data;
            r_tx    <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ext_bus.o_ext_ack   = r_ack;
  assign ext_bus.o_ext_dat_r = r_dat_r;
  assign o_tx  = r_tx;
  assign o_irq = r_irq_en & w_empty & (r_state == ST_IDLE);
endmodule

// File: tb/tb_ext_uart_tx.sv
// Self-checking bench for ext_uart_tx: register table, serial-line decoding
// of a recorded o_tx trace, backpressure, interrupt, held strobe, reset.
module tb_ext_uart_tx;
  import ext_bus_pkg::*;

  localparam int CD      = 4;
  localparam int FD      = 4;
  localparam int FRAME   = 10 * CD;
  localparam int TIMEOUT = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx;
  logic irq;

  ext_uart_tx_if bif();

  ext_uart_tx #(.CLK_DIV(CD), .FIFO_DEPTH(FD)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .ext_bus (bif),
    .o_tx    (tx),
    .o_irq   (irq)
  );

  always #5 clk = ~clk;

  // One o_tx sample per cycle, taken just after the rising edge.
  bit tx_log[$];
  always @(posedge clk) begin
    #1;
    tx_log.push_back(tx);
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Decoded 8N1 frames from a slice of the trace; each frame must hold every
  // bit level for exactly CD samples.
  logic [7:0] rx_bytes[$];
  int         rx_gaps[$];
  int         frame_bad;

  task automatic decode(input int from, input int to);
    int i;
    int gap;
    logic [9:0] bits;
    rx_bytes.delete();
    rx_gaps.delete();
    frame_bad = 0;
    i = from;
    gap = 0;
    while (i < to) begin
      if (tx_log[i]) begin
        gap++;
        i++;
      end else if (i + FRAME > to) begin
        frame_bad++;
        i = to;
      end else begin
        for (int b = 0; b < 10; b++) begin
          bits[b] = tx_log[i + b*CD];
          for (int c = 1; c < CD; c++)
            if (tx_log[i + b*CD + c] != bits[b]) frame_bad++;
        end
        if (bits[0] != 1'b0 || bits[9] != 1'b1) frame_bad++;
        rx_bytes.push_back(bits[8:1]);
        rx_gaps.push_back(gap);
        gap = 0;
        i += FRAME;
      end
    end
  endtask

  task automatic check_frames(input string name, input logic [7:0] exp[$]);
    check({name, "_count"}, rx_bytes.size(), exp.size());
    check({name, "_shape"}, frame_bad, 0);
    for (int k = 0; k < exp.size() && k < rx_bytes.size(); k++)
      check($sformatf("%s_byte%0d", name, k), rx_bytes[k], exp[k]);
  endtask

  task automatic bus_xfer(input string name, input logic [15:0] addr, input logic [3:0] we,
                          input logic [31:0] wd, output logic [31:0] rd, output int lat,
                          output int ack_idx);
    bif.i_ext_addr  = addr;
    bif.i_ext_we    = we;
    bif.i_ext_dat_w = wd;
    bif.i_ext_stb   = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bif.o_ext_ack && lat < TIMEOUT);
    check({name, "_ack"}, bif.o_ext_ack, 1'b1);
    rd      = bif.o_ext_dat_r;
    ack_idx = tx_log.size() - 1;
    bif.i_ext_stb = 1'b0;
    bif.i_ext_we  = 4'b0;
    @(negedge clk);
    check({name, "_ack_pulse"}, {bif.o_ext_ack, bif.o_ext_dat_r}, 33'd0);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [3:0]  we;
    logic [31:0] wdat;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t        vecs[15];
  logic [31:0] rd;
  int          lat;
  int          idx;
  int          mark;
  int          cnt;
  logic [7:0]  exp_q[$];
  logic        m_irq_en;
  logic [15:0] raddr;
  logic [3:0]  rwe;
  logic [31:0] rdat;

  initial begin
    bif.i_ext_addr  = '0;
    bif.i_ext_stb   = 1'b0;
    bif.i_ext_we    = '0;
    bif.i_ext_dat_w = '0;

    // Register accesses on an idle, empty transmitter.
    vecs[0]  = '{16'h0004, 4'b0000, 32'h0,         32'h0000_0002, 1'b0};
    vecs[1]  = '{16'h0000, 4'b0000, 32'h0,         32'h0,         1'b0};
    vecs[2]  = '{16'h0008, 4'b0000, 32'h0,         32'h0,         1'b0};
    vecs[3]  = '{16'h0008, 4'b0001, 32'h1,         32'h0,         1'b1};
    vecs[4]  = '{16'hFF08, 4'b0000, 32'h0,         32'h1,         1'b1};
    vecs[5]  = '{16'h0008, 4'b0010, 32'h0,         32'h0,         1'b1};
    vecs[6]  = '{16'h0008, 4'b0000, 32'h0,         32'h1,         1'b1};
    vecs[7]  = '{16'h0004, 4'b1111, 32'hFFFF_FFFF, 32'h0,         1'b1};
    vecs[8]  = '{16'h0004, 4'b0000, 32'h0,         32'h0000_0002, 1'b1};
    vecs[9]  = '{16'h000C, 4'b0000, 32'h0,         32'h0,         1'b1};
    vecs[10] = '{16'h000C, 4'b1111, 32'hFFFF_FFFF, 32'h0,         1'b1};
    vecs[11] = '{16'h0000, 4'b0010, 32'h0000_0077, 32'h0,         1'b1};
    vecs[12] = '{16'h1234, 4'b0000, 32'h0,         32'h0000_0002, 1'b1};
    vecs[13] = '{16'h0008, 4'b0001, 32'h0,         32'h0,         1'b0};
    vecs[14] = '{16'h0008, 4'b0000, 32'h0,         32'h0,         1'b0};

    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset_tx", tx, 1'b1);
    check("reset_irq", irq, 1'b0);
    check("reset_ack", bif.o_ext_ack, 1'b0);
    check("reset_rdata", bif.o_ext_dat_r, 32'h0);

    mark = tx_log.size() - 1;
    foreach (vecs[v]) begin
      bus_xfer($sformatf("vec%0d", v), vecs[v].addr, vecs[v].we, vecs[v].wdat, rd, lat, idx);
      check($sformatf("vec%0d_lat", v), lat, 1);
      if (vecs[v].we == 4'b0) check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rd);
      check($sformatf("vec%0d_irq", v), irq, vecs[v].exp_irq);
    end
    decode(mark, tx_log.size());
    exp_q = {};
    check_frames("table_no_tx", exp_q);

    // Single byte: start bit one cycle after the ack cycle, exact 40-cycle frame.
    bus_xfer("single", 16'h0000, 4'b0001, 32'h55, rd, lat, idx);
    check("single_lat", lat, 1);
    wait_cycles(FRAME + 10);
    decode(idx, tx_log.size());
    exp_q = {8'h55};
    check_frames("single", exp_q);
    if (rx_gaps.size() > 0) check("single_start_latency", rx_gaps[0], 1);
    bus_xfer("single_status", 16'h0004, 4'b0000, 32'h0, rd, lat, idx);
    check("single_status_rd", rd, 32'h0000_0002);

    // Back-to-back writes: the write after FD queued bytes meets a full FIFO.
    mark = tx_log.size() - 1;
    exp_q = {};
    for (int k = 0; k < 6; k++) begin
      if (k == FD + 1) begin
        bus_xfer("b2b_status", 16'h0004, 4'b0000, 32'h0, rd, lat, idx);
        check("b2b_status_full", rd, 32'h0000_0405);
      end
      bus_xfer($sformatf("b2b%0d", k), 16'h0000, 4'b0001, 32'hA0 + k, rd, lat, idx);
      exp_q.push_back(8'hA0 + 8'(k));
      if (k <= FD) check($sformatf("b2b%0d_lat", k), lat, 1);
      else         check("b2b_stall_lat", (lat > 1) && (lat <= FRAME), 1'b1);
    end
    wait_cycles(6 * FRAME + 20);
    decode(mark, tx_log.size());
    check_frames("b2b", exp_q);
    cnt = 0;
    for (int k = 1; k < rx_gaps.size(); k++) cnt += rx_gaps[k];
    check("b2b_contiguous", cnt, 0);

    // Interrupt: low for the whole frame, high once the stop bit has ended.
    bus_xfer("irq_en", 16'h0008, 4'b0001, 32'h1, rd, lat, idx);
    check("irq_idle_high", irq, 1'b1);
    bus_xfer("irq_data", 16'h0000, 4'b0001, 32'h0F, rd, lat, idx);
    cnt = 0;
    for (int k = 0; k < FRAME; k++) begin
      cnt += int'(irq);
      @(negedge clk);
    end
    check("irq_low_in_frame", cnt, 0);
    check("irq_after_stop", irq, 1'b1);
    decode(idx, tx_log.size());
    exp_q = {8'h0F};
    check_frames("irq_frame", exp_q);
    bus_xfer("irq_dis", 16'h0008, 4'b0001, 32'h0, rd, lat, idx);
    check("irq_cleared", irq, 1'b0);

    // Strobe held through the ack cycle must push exactly once.
    mark = tx_log.size() - 1;
    bif.i_ext_addr  = 16'h0000;
    bif.i_ext_we    = 4'b0001;
    bif.i_ext_dat_w = 32'h3C;
    bif.i_ext_stb   = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bif.o_ext_ack && lat < TIMEOUT);
    cnt = int'(bif.o_ext_ack);
    @(negedge clk);
    cnt += int'(bif.o_ext_ack);
    bif.i_ext_stb = 1'b0;
    bif.i_ext_we  = 4'b0;
    @(negedge clk);
    cnt += int'(bif.o_ext_ack);
    check("held_stb_acks", cnt, 1);
    wait_cycles(2 * FRAME + 10);
    decode(mark, tx_log.size());
    exp_q = {8'h3C};
    check_frames("held_stb", exp_q);

    // Randomized DATA pushes and CTRL traffic against a queue/register model.
    mark = tx_log.size() - 1;
    exp_q = {};
    m_irq_en = 1'b0;
    for (int k = 0; k < 14; k++) begin
      raddr = 16'($urandom) & 16'hFFF3;
      rdat  = $urandom;
      case ($urandom_range(0, 2))
        0: if (exp_q.size() < 6) begin
          rwe = 4'($urandom) | 4'b0001;
          bus_xfer("rnd_data", raddr | 16'h0000, rwe, rdat, rd, lat, idx);
          exp_q.push_back(rdat[7:0]);
        end
        1: begin
          rwe = 4'($urandom);
          bus_xfer("rnd_ctrl_w", raddr | 16'h0008, rwe, rdat, rd, lat, idx);
          if (rwe[0]) m_irq_en = rdat[0];
        end
        default: begin
          bus_xfer("rnd_ctrl_r", raddr | 16'h0008, 4'b0000, 32'h0, rd, lat, idx);
          check("rnd_ctrl_rd", rd, {31'b0, m_irq_en});
        end
      endcase
    end
    wait_cycles(exp_q.size() * FRAME + 20);
    decode(mark, tx_log.size());
    check_frames("rnd", exp_q);
    check("rnd_irq_idle", irq, m_irq_en);
    bus_xfer("rnd_irq_off", 16'h0008, 4'b0001, 32'h0, rd, lat, idx);

    // Mid-frame reset during bit 3 of 0x96 with more bytes queued.
    bus_xfer("rst_d0", 16'h0000, 4'b0001, 32'h96, rd, lat, idx);
    mark = idx;
    bus_xfer("rst_d1", 16'h0000, 4'b0001, 32'h11, rd, lat, idx);
    bus_xfer("rst_d2", 16'h0000, 4'b0001, 32'h22, rd, lat, idx);
    wait_cycles(mark + 1 + 4*CD + 1 - (tx_log.size() - 1));
    check("rst_bit3_low", tx, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_tx", tx, 1'b1);
    check("rst_async_ack", bif.o_ext_ack, 1'b0);
    wait_cycles(3);
    #2 rst_n = 1'b1;
    @(negedge clk);
    mark = tx_log.size() - 1;
    wait_cycles(3 * FRAME);
    decode(mark, tx_log.size());
    exp_q = {};
    check_frames("rst_no_resume", exp_q);
    bus_xfer("rst_status", 16'h0004, 4'b0000, 32'h0, rd, lat, idx);
    check("rst_status_rd", rd, 32'h0000_0002);
    bus_xfer("rst_ctrl", 16'h0008, 4'b0000, 32'h0, rd, lat, idx);
    check("rst_ctrl_rd", rd, 32'h0);
    check("rst_irq", irq, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
